// File: rtl/nic2noc_vc_tracker.sv
// nic2noc_vc_tracker: output stage between the wishbone slave interface and the
// router input port. Tracks per-VC ownership, outstanding flits and lifecycle,
// registers the winning flit onto the link and returns router credits to the
// fifo_out_buffer that owns each VC.
//
//   state    | meaning
//   VC_IDLE  | VC free, offered to the VC allocator (vc_idle_o[v]=1)
//   VC_BUSY  | VC owned by a fifo_out_buffer, packet in flight
//   VC_DRAIN | tail sent, waiting for the router to return outstanding credits

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module nic2noc_vc_tracker #(
  parameter int N_FIFO_OUT_BUFFER      = 6,
  parameter int N_BITS_FIFO_OUT_BUFFER = 3,
  parameter int N_TOT_OF_VC            = 6,
  parameter int N_BITS_CREDIT          = 4,
  parameter int MAX_CREDIT             = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_TOT_OF_VC-1:0]                        g_fifo_pointer_i,
  input  logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] g_fifo_out_buffer_id_i,
  input  logic [N_TOT_OF_VC-1:0]                        release_pointer_i,
  input  logic [`FLIT_WIDTH-1:0]                        in_link_i,
  input  logic                                          is_valid_i,
  input  logic [N_TOT_OF_VC-1:0]                        in_vc_i,
  input  logic [N_TOT_OF_VC-1:0]                        credit_from_router_i,
  output logic [`FLIT_WIDTH-1:0]                        out_link_o,
  output logic                                          is_valid_o,
  output logic [N_TOT_OF_VC-1:0]                        credit_signal_o,
  output logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] fifo_pointed_o,
  output logic [N_TOT_OF_VC-1:0]                        vc_idle_o,
  output logic                                          error_o
);

  localparam int IDW = N_BITS_FIFO_OUT_BUFFER;
  localparam logic [N_BITS_CREDIT-1:0] CNT_MAX  = N_BITS_CREDIT'(MAX_CREDIT);
  localparam logic [N_BITS_CREDIT-1:0] CNT_ONE  = N_BITS_CREDIT'(1);
  localparam logic [N_BITS_CREDIT-1:0] CNT_ZERO = '0;

  // Owner ids must fit their field and the counter must be able to hold MAX_CREDIT.
  if ((N_FIFO_OUT_BUFFER > (1 << IDW)) || (MAX_CREDIT > ((1 << N_BITS_CREDIT) - 1))) begin : g_bad_params
    $error("nic2noc_vc_tracker: parameter combination out of range");
  end

  typedef enum logic [1:0] {
    VC_IDLE  = 2'd0,
    VC_BUSY  = 2'd1,
    VC_DRAIN = 2'd2
  } vc_state_e;

  vc_state_e                 state_q [N_TOT_OF_VC];
  logic [N_BITS_CREDIT-1:0]  cnt_q   [N_TOT_OF_VC];
  logic [N_BITS_CREDIT-1:0]  cnt_d   [N_TOT_OF_VC];
  logic [IDW-1:0]            owner_q [N_TOT_OF_VC];

  logic [`FLIT_WIDTH-1:0]                out_link_q;
  logic                                  is_valid_q;
  logic [N_TOT_OF_VC-1:0]                credit_q;
  logic [N_TOT_OF_VC*IDW-1:0]            fifo_pointed_q;
  logic [N_TOT_OF_VC-1:0]                vc_idle_q;
  logic                                  error_q;

  logic [N_TOT_OF_VC-1:0] vc_minus_one;
  logic                   in_vc_onehot;
  logic [N_TOT_OF_VC-1:0] flit_hit;
  logic [N_TOT_OF_VC-1:0] credit_ok;
  logic [N_TOT_OF_VC-1:0] vc_err;
  logic                   err_any;

  // Per-VC counter update and protocol-violation detection.
  // A forwarded flit occupies a router slot whatever the VC state, so it is counted
  // even when it also raises an error; a flit whose VC is not one-hot cannot be
  // attributed to any VC and is only forwarded.
  always_comb begin
    vc_minus_one = in_vc_i - {{(N_TOT_OF_VC-1){1'b0}}, 1'b1};
    in_vc_onehot = (in_vc_i != '0) && ((in_vc_i & vc_minus_one) == '0);
    flit_hit     = '0;
    credit_ok    = '0;
    vc_err       = '0;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      cnt_d[v]     = cnt_q[v];
      flit_hit[v]  = is_valid_i && in_vc_onehot && in_vc_i[v];
      credit_ok[v] = credit_from_router_i[v] && (cnt_q[v] != CNT_ZERO);
      if (flit_hit[v] && credit_ok[v]) begin
        cnt_d[v] = cnt_q[v];
      end else if (flit_hit[v] && (cnt_q[v] != CNT_MAX)) begin
        cnt_d[v] = cnt_q[v] + CNT_ONE;
      end else if (credit_ok[v]) begin
        cnt_d[v] = cnt_q[v] - CNT_ONE;
      end
      vc_err[v] = (g_fifo_pointer_i[v] && (state_q[v] != VC_IDLE))
               || (release_pointer_i[v] && (state_q[v] != VC_BUSY))
               || (flit_hit[v] && ((state_q[v] != VC_BUSY) || (cnt_q[v] == CNT_MAX)))
               || (credit_from_router_i[v] && (cnt_q[v] == CNT_ZERO));
    end
    err_any = (|vc_err) || (is_valid_i && !in_vc_onehot);
  end

  // VC lifecycle FSMs, counters, owners and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        state_q[v] <= VC_IDLE;
        cnt_q[v]   <= '0;
        owner_q[v] <= '0;
      end
      out_link_q     <= '0;
      is_valid_q     <= 1'b0;
      credit_q       <= '0;
      fifo_pointed_q <= '0;
      vc_idle_q      <= '1;
      error_q        <= 1'b0;
    end else begin
      if (is_valid_i) begin
        out_link_q <= in_link_i;
      end
      is_valid_q <= is_valid_i;
      error_q    <= error_q | err_any;
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        cnt_q[v]    <= cnt_d[v];
        credit_q[v] <= credit_ok[v];
        // Credits are steered to the recorded owner, which survives DRAIN->IDLE.
        fifo_pointed_q[v*IDW +: IDW] <= credit_ok[v] ? owner_q[v] : '0;
        case (state_q[v])
          VC_IDLE: begin
            if (g_fifo_pointer_i[v]) begin
              owner_q[v]   <= g_fifo_out_buffer_id_i[v*IDW +: IDW];
              state_q[v]   <= VC_BUSY;
              vc_idle_q[v] <= 1'b0;
            end
          end
          VC_BUSY: begin
            if (release_pointer_i[v]) begin
              if (cnt_d[v] == CNT_ZERO) begin
                state_q[v]   <= VC_IDLE;
                vc_idle_q[v] <= 1'b1;
              end else begin
                state_q[v]   <= VC_DRAIN;
              end
            end
          end
          VC_DRAIN: begin
            if (cnt_d[v] == CNT_ZERO) begin
              state_q[v]   <= VC_IDLE;
              vc_idle_q[v] <= 1'b1;
            end
          end
          default: begin
            state_q[v]   <= VC_IDLE;
            vc_idle_q[v] <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out_link_o      = out_link_q;
  assign is_valid_o      = is_valid_q;
  assign credit_signal_o = credit_q;
  assign fifo_pointed_o  = fifo_pointed_q;
  assign vc_idle_o       = vc_idle_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_nic2noc_vc_tracker.sv
// Testbench for nic2noc_vc_tracker: scenario tasks drive stimulus and push the
// expected forwarded flits / credit pulses into queues; every clock step pops
// and compares them against what the DUT produced.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module tb_nic2noc_vc_tracker;

  localparam int NV = 6;
  localparam int IW = 3;
  localparam int FW = `FLIT_WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NV-1:0]     g_fifo_pointer_i = '0;
  logic [NV*IW-1:0]  g_fifo_out_buffer_id_i = '0;
  logic [NV-1:0]     release_pointer_i = '0;
  logic [FW-1:0]     in_link_i = '0;
  logic              is_valid_i = 1'b0;
  logic [NV-1:0]     in_vc_i = '0;
  logic [NV-1:0]     credit_from_router_i = '0;
  logic [FW-1:0]     out_link_o;
  logic              is_valid_o;
  logic [NV-1:0]     credit_signal_o;
  logic [NV*IW-1:0]  fifo_pointed_o;
  logic [NV-1:0]     vc_idle_o;
  logic              error_o;

  typedef struct {
    int          vc;
    logic [IW-1:0] owner;
  } cred_t;

  cred_t         cq[$];
  logic [FW-1:0] fq[$];
  int errors = 0;
  int checks = 0;

  nic2noc_vc_tracker dut (
    .clk                    (clk),
    .rst                    (rst),
    .g_fifo_pointer_i       (g_fifo_pointer_i),
    .g_fifo_out_buffer_id_i (g_fifo_out_buffer_id_i),
    .release_pointer_i      (release_pointer_i),
    .in_link_i              (in_link_i),
    .is_valid_i             (is_valid_i),
    .in_vc_i                (in_vc_i),
    .credit_from_router_i   (credit_from_router_i),
    .out_link_o             (out_link_o),
    .is_valid_o             (is_valid_o),
    .credit_signal_o        (credit_signal_o),
    .fifo_pointed_o         (fifo_pointed_o),
    .vc_idle_o              (vc_idle_o),
    .error_o                (error_o)
  );

  always #5 clk = ~clk;

  // One clock step: clear pulse inputs, then score flits and credit pulses.
  task automatic tick();
    cred_t         c;
    logic [FW-1:0] f;
    @(posedge clk);
    #1;
    g_fifo_pointer_i     = '0;
    release_pointer_i    = '0;
    is_valid_i           = 1'b0;
    in_vc_i              = '0;
    credit_from_router_i = '0;
    if (is_valid_o) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL flit_unexpected got=%h", out_link_o);
      end else begin
        f = fq.pop_front();
        if (out_link_o !== f) begin
          errors++;
          $display("FAIL flit_data got=%h exp=%h", out_link_o, f);
        end
      end
    end
    if (fq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL flit_missing pending=%0d is_valid_o=%b", fq.size(), is_valid_o);
      fq.delete();
    end
    for (int v = 0; v < NV; v++) begin
      if (credit_signal_o[v]) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL credit_unexpected vc=%0d owner=%0d", v, fifo_pointed_o[v*IW +: IW]);
        end else begin
          c = cq.pop_front();
          if (c.vc != v || fifo_pointed_o[v*IW +: IW] !== c.owner) begin
            errors++;
            $display("FAIL credit_pulse got vc=%0d owner=%0d exp vc=%0d owner=%0d",
                     v, fifo_pointed_o[v*IW +: IW], c.vc, c.owner);
          end
        end
      end
    end
    if (cq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL credit_missing pending=%0d credit_signal_o=%b", cq.size(), credit_signal_o);
      cq.delete();
    end
  endtask

  task automatic grant(input int v, input int id);
    logic [31:0] idv;
    idv = id;
    g_fifo_pointer_i[v] = 1'b1;
    g_fifo_out_buffer_id_i[v*IW +: IW] = idv[IW-1:0];
  endtask

  task automatic flit(input int v);
    logic [FW-1:0] d;
    d = FW'($urandom);
    is_valid_i = 1'b1;
    in_vc_i    = '0;
    in_vc_i[v] = 1'b1;
    in_link_i  = d;
    fq.push_back(d);
  endtask

  // Callers within one cycle must go in ascending VC order.
  task automatic cred(input int v, input bit fwd, input int owner);
    cred_t       c;
    logic [31:0] ov;
    ov = owner;
    credit_from_router_i[v] = 1'b1;
    if (fwd) begin
      c.vc    = v;
      c.owner = ov[IW-1:0];
      cq.push_back(c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fq.delete();
    cq.delete();
  endtask

  task automatic test_reset();
    checks++;
    if (vc_idle_o !== 6'h3F || is_valid_o !== 1'b0 || credit_signal_o !== '0 ||
        fifo_pointed_o !== '0 || out_link_o !== '0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state idle=%h val=%b cred=%h fp=%h link=%h err=%b",
               vc_idle_o, is_valid_o, credit_signal_o, fifo_pointed_o, out_link_o, error_o);
    end
    grant(2, 1); tick();
    for (int i = 0; i < 3; i++) begin
      flit(2); tick();
    end
    rst = 1'b1;
    #2;
    checks++;
    if (vc_idle_o !== 6'h3F || is_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset idle=%h val=%b exp idle=3f val=0", vc_idle_o, is_valid_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (vc_idle_o !== 6'h3F || is_valid_o !== 1'b0 || credit_signal_o !== '0 ||
        fifo_pointed_o !== '0 || out_link_o !== '0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_reset idle=%h val=%b cred=%h fp=%h link=%h err=%b",
               vc_idle_o, is_valid_o, credit_signal_o, fifo_pointed_o, out_link_o, error_o);
    end
    rst = 1'b0;
    cred(2, 1'b0, 0); tick();
    checks++;
    if (error_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_cnt_cleared error_o=%b exp=1", error_o);
    end
    do_reset();
  endtask

  task automatic test_grant_release();
    grant(1, 4); tick();
    checks++;
    if (vc_idle_o !== 6'h3D) begin
      errors++;
      $display("FAIL grant_vc1_idle got=%h exp=3d", vc_idle_o);
    end
    for (int i = 0; i < 3; i++) begin
      flit(1); tick();
    end
    release_pointer_i[1] = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      cred(1, 1'b1, 4); tick();
      checks++;
      if (vc_idle_o[1] !== (i == 2)) begin
        errors++;
        $display("FAIL drain_vc1_idle credit=%0d got=%b exp=%b", i + 1, vc_idle_o[1], (i == 2));
      end
    end
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL grant_release_error got=%b exp=0", error_o);
    end
  endtask

  task automatic test_flit_credit_same_cycle();
    grant(0, 2); tick();
    flit(0); tick();
    flit(0); tick();
    flit(0); cred(0, 1'b1, 2); tick();
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL flit_credit_error got=%b exp=0", error_o);
    end
    cred(0, 1'b1, 2); tick();
    cred(0, 1'b1, 2); tick();
    release_pointer_i[0] = 1'b1; tick();
    checks++;
    if (vc_idle_o[0] !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL flit_credit_cnt idle0=%b err=%b exp idle0=1 err=0", vc_idle_o[0], error_o);
    end
  endtask

  task automatic test_saturate();
    grant(3, 5); tick();
    for (int i = 0; i < 8; i++) begin
      flit(3); tick();
    end
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_8_flits error_o=%b exp=0", error_o);
    end
    flit(3); tick();
    checks++;
    if (error_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_9th_flit error_o=%b exp=1", error_o);
    end
    for (int i = 0; i < 8; i++) begin
      cred(3, 1'b1, 5); tick();
    end
    cred(3, 1'b0, 0); tick();
    checks++;
    if (credit_signal_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL sat_9th_credit got=%b exp=0", credit_signal_o[3]);
    end
    do_reset();
  endtask

  task automatic test_errors();
    cred(5, 1'b0, 0); tick();
    checks++;
    if (credit_signal_o[5] !== 1'b0 || error_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_credit cred5=%b err=%b exp cred5=0 err=1", credit_signal_o[5], error_o);
    end
    do_reset();
    grant(2, 3); tick();
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL first_grant error_o=%b exp=0", error_o);
    end
    grant(2, 6); tick();
    checks++;
    if (error_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_grant error_o=%b exp=1", error_o);
    end
    flit(2); tick();
    cred(2, 1'b1, 3); tick();
    do_reset();
  endtask

  task automatic test_release_last_credit();
    grant(4, 1); tick();
    flit(4); tick();
    release_pointer_i[4] = 1'b1; cred(4, 1'b1, 1); tick();
    checks++;
    if (vc_idle_o[4] !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL release_last idle4=%b err=%b exp idle4=1 err=0", vc_idle_o[4], error_o);
    end
    grant(4, 7); tick();
    checks++;
    if (vc_idle_o[4] !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL regrant idle4=%b err=%b exp idle4=0 err=0", vc_idle_o[4], error_o);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    grant(0, 0); grant(5, 5); tick();
    flit(0); tick();
    flit(5); tick();
    flit(0); tick();
    cred(0, 1'b1, 0); cred(5, 1'b1, 5); tick();
    cred(0, 1'b1, 0); tick();
    release_pointer_i = 6'b100001; tick();
    checks++;
    if (vc_idle_o !== 6'h3F || error_o !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back idle=%h err=%b exp idle=3f err=0", vc_idle_o, error_o);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_grant_release();
    test_flit_credit_same_cycle();
    test_saturate();
    test_errors();
    test_release_last_credit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
